// File: rtl/ucore_cfg_pkg.sv
// Shared definitions for the ucore configuration cache: header field layout,
// receive FSM states and frame length helper.
package ucore_cfg_pkg;

  localparam int unsigned TARGET_ID_W = 8;
  localparam int unsigned HDR_OP_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FWD
  } fsm_state_e;

  // Total beats in one frame: header plus constants.
  function automatic int unsigned frame_beats(input int unsigned const_count);
    return const_count + 1;
  endfunction

endpackage

// File: rtl/ucore_cfg_frame_rx.sv
// Config chain receiver: splits frames into local loads and forwarded traffic,
// stages a local frame and raises a one-cycle commit strobe once it is complete.
// Optional even-parity checking of consumed beats under UCORE_CFG_PARITY_EN.
module ucore_cfg_frame_rx
  import ucore_cfg_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            OP_WIDTH    = 8,
  parameter int unsigned            CONST_COUNT = 4,
  parameter int unsigned            IDX_W       = 2,
  parameter logic [TARGET_ID_W-1:0] UCORE_ID    = '0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   cfg_in_vld,
  input  logic [DATA_WIDTH-1:0]                  cfg_in_data,
`ifdef UCORE_CFG_PARITY_EN
  input  logic                                   cfg_in_par,
`endif
  output logic                                   cfg_out_vld,
  output logic [DATA_WIDTH-1:0]                  cfg_out_data,
  output logic                                   commit,
  output logic [IDX_W-1:0]                       commit_idx,
  output logic [OP_WIDTH-1:0]                    commit_op,
  output logic [CONST_COUNT-1:0][DATA_WIDTH-1:0] commit_consts,
  output logic                                   frame_err
);

  localparam int unsigned CNT_W = $clog2(frame_beats(CONST_COUNT));

  fsm_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] slot;
  logic             id_hit;
  logic             last_beat;
  logic             frame_bad;

  // Header match, constant slot being written and last-beat detect.
  always_comb begin
    id_hit    = (cfg_in_data[DATA_WIDTH-1 -: TARGET_ID_W] == UCORE_ID);
    slot      = CNT_W'(CONST_COUNT) - cnt;
    last_beat = (cnt == CNT_W'(1));
  end

  // Next-state decode; gaps (vld=0) hold the current state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (cfg_in_vld) state_nxt = id_hit ? LOAD : FWD;
      LOAD, FWD: if (cfg_in_vld && last_beat) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Beat counter, staging buffer, forward register and commit strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      cfg_out_vld   <= 1'b0;
      cfg_out_data  <= '0;
      commit        <= 1'b0;
      commit_idx    <= '0;
      commit_op     <= '0;
      commit_consts <= '0;
    end else begin
      commit      <= 1'b0;
      cfg_out_vld <= 1'b0;
      if (cfg_in_vld) begin
        case (state)
          IDLE: begin
            cnt <= CNT_W'(CONST_COUNT);
            if (id_hit) begin
              commit_op  <= cfg_in_data[HDR_OP_LSB +: OP_WIDTH];
              commit_idx <= cfg_in_data[HDR_OP_LSB + OP_WIDTH +: IDX_W];
            end else begin
              cfg_out_vld  <= 1'b1;
              cfg_out_data <= cfg_in_data;
            end
          end
          LOAD: begin
            cnt <= cnt - 1'b1;
            for (int unsigned i = 0; i < CONST_COUNT; i++) begin
              if (slot == CNT_W'(i)) commit_consts[i] <= cfg_in_data;
            end
            if (last_beat) commit <= !frame_bad;
          end
          FWD: begin
            cnt          <= cnt - 1'b1;
            cfg_out_vld  <= 1'b1;
            cfg_out_data <= cfg_in_data;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef UCORE_CFG_PARITY_EN
  logic beat_bad;
  logic bad_seen;

  assign beat_bad  = ((^cfg_in_data) != cfg_in_par);
  assign frame_bad = bad_seen | beat_bad;

  // Accumulate parity faults over a loaded frame; report on its last beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bad_seen  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (cfg_in_vld) begin
        if (state == IDLE) begin
          bad_seen <= beat_bad;
        end else if (state == LOAD) begin
          bad_seen <= frame_bad;
          if (last_beat) frame_err <= frame_bad;
        end
      end
    end
  end
`else
  assign frame_bad = 1'b0;
  assign frame_err = 1'b0;
`endif

endmodule

// File: rtl/ucore_cfg_cache.sv
// Multi-entry configuration cache for one RipTide ucore. Frames from the cfg
// chain commit into the cache; a req/ack switch selects the entry driving the
// FU. Parity checking of loaded beats is enabled by UCORE_CFG_PARITY_EN.
module ucore_cfg_cache
  import ucore_cfg_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            OP_WIDTH    = 8,
  parameter int unsigned            CONST_COUNT = 4,
  parameter int unsigned            CACHE_DEPTH = 4,
  parameter logic [TARGET_ID_W-1:0] UCORE_ID    = '0,
  localparam int unsigned           IDX_W       = $clog2(CACHE_DEPTH)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   cfg_in_vld,
  input  logic [DATA_WIDTH-1:0]                  cfg_in_data,
`ifdef UCORE_CFG_PARITY_EN
  input  logic                                   cfg_in_par,
`endif
  output logic                                   cfg_out_vld,
  output logic [DATA_WIDTH-1:0]                  cfg_out_data,
  input  logic                                   sw_req,
  input  logic [IDX_W-1:0]                       sw_idx,
  input  logic                                   fu_idle,
  output logic                                   sw_ack,
  output logic                                   sw_err,
  output logic                                   cfg_valid,
  output logic [OP_WIDTH-1:0]                    cfg_op,
  output logic [CONST_COUNT-1:0][DATA_WIDTH-1:0] constants,
  output logic [IDX_W-1:0]                       active_idx,
  output logic [CACHE_DEPTH-1:0]                 entry_vld,
  output logic                                   cfg_err
);

  logic                                   commit;
  logic [IDX_W-1:0]                       commit_idx;
  logic [OP_WIDTH-1:0]                    commit_op;
  logic [CONST_COUNT-1:0][DATA_WIDTH-1:0] commit_consts;
  logic                                   frame_err;

  logic [OP_WIDTH-1:0]                    cache_op    [CACHE_DEPTH];
  logic [CONST_COUNT-1:0][DATA_WIDTH-1:0] cache_const [CACHE_DEPTH];

  logic commit_hit, commit_ok, sw_go, sw_bad, sw_ok;

  ucore_cfg_frame_rx #(
    .DATA_WIDTH  (DATA_WIDTH),
    .OP_WIDTH    (OP_WIDTH),
    .CONST_COUNT (CONST_COUNT),
    .IDX_W       (IDX_W),
    .UCORE_ID    (UCORE_ID)
  ) u_rx (
    .clk           (clk),
    .reset         (reset),
    .cfg_in_vld    (cfg_in_vld),
    .cfg_in_data   (cfg_in_data),
`ifdef UCORE_CFG_PARITY_EN
    .cfg_in_par    (cfg_in_par),
`endif
    .cfg_out_vld   (cfg_out_vld),
    .cfg_out_data  (cfg_out_data),
    .commit        (commit),
    .commit_idx    (commit_idx),
    .commit_op     (commit_op),
    .commit_consts (commit_consts),
    .frame_err     (frame_err)
  );

  // Commit/switch arbitration. A request is ignored in the cycle its own
  // ack/err is visible so a requester that drops req on seeing the pulse
  // never receives a second one.
  always_comb begin
    commit_hit = commit && cfg_valid && (commit_idx == active_idx);
    commit_ok  = commit && !commit_hit;
    sw_go      = sw_req && !sw_ack && !sw_err;
    sw_bad     = sw_go && !entry_vld[sw_idx];
    sw_ok      = sw_go && entry_vld[sw_idx] && fu_idle &&
                 !(commit && (commit_idx == sw_idx));
  end

  // Cache storage and per-entry valid bitmap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_vld <= '0;
      for (int unsigned i = 0; i < CACHE_DEPTH; i++) begin
        cache_op[i]    <= '0;
        cache_const[i] <= '0;
      end
    end else if (commit_ok) begin
      entry_vld[commit_idx]   <= 1'b1;
      cache_op[commit_idx]    <= commit_op;
      cache_const[commit_idx] <= commit_consts;
    end
  end

  // Active entry selection, switch handshake and registered FU outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_ack     <= 1'b0;
      sw_err     <= 1'b0;
      cfg_valid  <= 1'b0;
      active_idx <= '0;
      cfg_op     <= '0;
      constants  <= '0;
    end else begin
      sw_ack <= sw_ok;
      sw_err <= sw_bad;
      if (commit_ok && !cfg_valid) begin
        cfg_valid  <= 1'b1;
        active_idx <= commit_idx;
        cfg_op     <= commit_op;
        constants  <= commit_consts;
      end else if (sw_ok) begin
        active_idx <= sw_idx;
        cfg_op     <= cache_op[sw_idx];
        constants  <= cache_const[sw_idx];
      end
    end
  end

  // Sticky error: overwrite of the live entry or a corrupted loaded frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cfg_err <= 1'b0;
    else       cfg_err <= cfg_err | commit_hit | frame_err;
  end

endmodule

// File: tb/tb_ucore_cfg_cache.sv
// Self-checking bench for ucore_cfg_cache: directed frame table, switch and
// reset corner sequences, then randomized traffic against a frame-level model.
// Parity sequences are included when UCORE_CFG_PARITY_EN is defined.
module tb_ucore_cfg_cache;

  localparam logic [7:0] UCORE_ID = 8'h00;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_in_vld = 1'b0;
  logic [31:0]       cfg_in_data = '0;
`ifdef UCORE_CFG_PARITY_EN
  logic              cfg_in_par = 1'b0;
`endif
  logic              cfg_out_vld;
  logic [31:0]       cfg_out_data;
  logic              sw_req = 1'b0;
  logic [1:0]        sw_idx = '0;
  logic              fu_idle = 1'b1;
  logic              sw_ack, sw_err, cfg_valid;
  logic [7:0]        cfg_op;
  logic [3:0][31:0]  constants;
  logic [1:0]        active_idx;
  logic [3:0]        entry_vld;
  logic              cfg_err;

  int n_vec = 0;
  int n_err = 0;

  // Frame-level reference model of the cache contents.
  bit          m_vld [4];
  logic [7:0]  m_op  [4];
  logic [127:0] m_cs [4];
  bit          m_valid;
  logic [1:0]  m_act;
  bit          m_err;

  ucore_cfg_cache #(
    .DATA_WIDTH  (32),
    .OP_WIDTH    (8),
    .CONST_COUNT (4),
    .CACHE_DEPTH (4),
    .UCORE_ID    (UCORE_ID)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_in_vld   (cfg_in_vld),
    .cfg_in_data  (cfg_in_data),
`ifdef UCORE_CFG_PARITY_EN
    .cfg_in_par   (cfg_in_par),
`endif
    .cfg_out_vld  (cfg_out_vld),
    .cfg_out_data (cfg_out_data),
    .sw_req       (sw_req),
    .sw_idx       (sw_idx),
    .fu_idle      (fu_idle),
    .sw_ack       (sw_ack),
    .sw_err       (sw_err),
    .cfg_valid    (cfg_valid),
    .cfg_op       (cfg_op),
    .constants    (constants),
    .active_idx   (active_idx),
    .entry_vld    (entry_vld),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_vld[i] = 0;
      m_op[i]  = '0;
      m_cs[i]  = '0;
    end
    m_valid = 0;
    m_act   = '0;
    m_err   = 0;
  endtask

  task automatic model_frame(input logic [7:0] id, input logic [7:0] op, input logic [1:0] idx,
                             input logic [127:0] cs, input bit bad);
    if (id != UCORE_ID) return;
    if (bad || (m_valid && idx == m_act)) begin
      m_err = 1;
      return;
    end
    m_vld[idx] = 1;
    m_op[idx]  = op;
    m_cs[idx]  = cs;
    if (!m_valid) begin
      m_valid = 1;
      m_act   = idx;
    end
  endtask

  task automatic chk_state(input string tag);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_vld[i];
    chk({tag, ".entry_vld"},  128'(entry_vld),  128'(v));
    chk({tag, ".cfg_valid"},  128'(cfg_valid),  128'(m_valid));
    chk({tag, ".active_idx"}, 128'(active_idx), 128'(m_valid ? m_act : 2'd0));
    chk({tag, ".cfg_op"},     128'(cfg_op),     128'(m_valid ? m_op[m_act] : 8'd0));
    chk({tag, ".constants"},  128'(constants),  m_valid ? m_cs[m_act] : 128'd0);
    chk({tag, ".cfg_err"},    128'(cfg_err),    128'(m_err));
  endtask

  task automatic do_reset();
    cfg_in_vld  = 1'b0;
    cfg_in_data = '0;
    sw_req      = 1'b0;
    sw_idx      = '0;
    fu_idle     = 1'b1;
    #2 reset = 1'b1;
    #2;
    chk("rst.cfg_valid",   128'(cfg_valid),   '0);
    chk("rst.entry_vld",   128'(entry_vld),   '0);
    chk("rst.cfg_op",      128'(cfg_op),      '0);
    chk("rst.constants",   128'(constants),   '0);
    chk("rst.active_idx",  128'(active_idx),  '0);
    chk("rst.cfg_err",     128'(cfg_err),     '0);
    chk("rst.cfg_out_vld", 128'(cfg_out_vld), '0);
    chk("rst.sw_pulses",   128'({sw_ack, sw_err}), '0);
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  // Drive one frame with optional random gaps; checks forwarding per beat and,
  // when settle is set, the exact commit edge and the resulting state.
  task automatic send_frame(input logic [7:0] id, input logic [7:0] op, input logic [1:0] idx,
                            input logic [127:0] cs, input int max_gap, input int bad_beat,
                            input bit settle);
    logic [31:0] beat;
    bit fwd;
    fwd = (id != UCORE_ID);
    for (int b = 0; b < 5; b++) begin
      int gaps;
      gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gaps; g++) begin
        cfg_in_vld = 1'b0;
        tick();
        chk("gap.cfg_out_vld", 128'(cfg_out_vld), '0);
      end
      beat = (b == 0) ? {id, 14'd0, idx, op} : cs[(b-1)*32 +: 32];
      cfg_in_vld  = 1'b1;
      cfg_in_data = beat;
`ifdef UCORE_CFG_PARITY_EN
      cfg_in_par  = (^beat) ^ (b == bad_beat);
`endif
      tick();
      chk("fwd.cfg_out_vld", 128'(cfg_out_vld), 128'(fwd));
      if (fwd) chk("fwd.cfg_out_data", 128'(cfg_out_data), 128'(beat));
    end
    cfg_in_vld = 1'b0;
    if (settle) begin
      chk_state("pre_commit");
      tick();
      chk("tail.cfg_out_vld", 128'(cfg_out_vld), '0);
      model_frame(id, op, idx, cs, bad_beat >= 0);
      chk_state("post_commit");
    end
  endtask

  task automatic do_switch(input logic [1:0] idx, input int delay);
    int c;
    bit want_err;
    int want_c;
    want_err = !m_vld[idx];
    want_c   = want_err ? 0 : delay;
    sw_req = 1'b1;
    sw_idx = idx;
    c = 0;
    while (c < 16) begin
      fu_idle = (c >= delay);
      tick();
      if (sw_ack || sw_err) break;
      c++;
    end
    chk("sw.cycle", 128'(c), 128'(want_c));
    chk("sw.kind", 128'({sw_ack, sw_err}), want_err ? 128'd1 : 128'd2);
    if (!want_err) m_act = idx;
    chk_state("sw_done");
    sw_req  = 1'b0;
    fu_idle = 1'b1;
    tick();
    chk("sw.pulse", 128'({sw_ack, sw_err}), '0);
  endtask

  typedef struct {
    logic [7:0]   id;
    logic [7:0]   op;
    logic [1:0]   idx;
    logic [127:0] cs;
    logic [3:0]   e_vld;
    logic         e_valid;
    logic [1:0]   e_act;
    logic [7:0]   e_op;
    logic [127:0] e_cs;
    logic         e_err;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [127:0] c1, c2, c3, c4, c5;
    c1 = {32'd4, 32'd3, 32'd2, 32'd1};
    c2 = {32'hd, 32'hc, 32'hb, 32'ha};
    c3 = {32'd9, 32'd9, 32'd9, 32'd9};
    c4 = {32'h44, 32'h33, 32'h22, 32'h11};
    c5 = {32'h55, 32'h56, 32'h57, 32'h58};
    tbl[0] = '{8'h00, 8'h12, 2'd1, c1, 4'b0010, 1'b1, 2'd1, 8'h12, c1, 1'b0};
    tbl[1] = '{8'h01, 8'h55, 2'd2, c5, 4'b0010, 1'b1, 2'd1, 8'h12, c1, 1'b0};
    tbl[2] = '{8'h00, 8'h34, 2'd2, c2, 4'b0110, 1'b1, 2'd1, 8'h12, c1, 1'b0};
    tbl[3] = '{8'h00, 8'h77, 2'd1, c3, 4'b0110, 1'b1, 2'd1, 8'h12, c1, 1'b1};
    tbl[4] = '{8'h80, 8'h01, 2'd0, c5, 4'b0110, 1'b1, 2'd1, 8'h12, c1, 1'b1};
    tbl[5] = '{8'h00, 8'h9a, 2'd0, c4, 4'b0111, 1'b1, 2'd1, 8'h12, c1, 1'b1};

    model_reset();
    do_reset();

    // Directed frame table: load, forward, second load, overwrite of active.
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].id, tbl[i].op, tbl[i].idx, tbl[i].cs, 1, -1, 1);
      chk("tbl.entry_vld",  128'(entry_vld),  128'(tbl[i].e_vld));
      chk("tbl.cfg_valid",  128'(cfg_valid),  128'(tbl[i].e_valid));
      chk("tbl.active_idx", 128'(active_idx), 128'(tbl[i].e_act));
      chk("tbl.cfg_op",     128'(cfg_op),     128'(tbl[i].e_op));
      chk("tbl.constants",  128'(constants),  tbl[i].e_cs);
      chk("tbl.cfg_err",    128'(cfg_err),    128'(tbl[i].e_err));
    end

    // Switch waits for fu_idle; invalid entry errors; same entry acks.
    do_switch(2'd2, 3);
    chk("sw2.cfg_op", 128'(cfg_op), 128'(8'h34));
    do_switch(2'd3, 0);
    do_switch(2'd2, 0);
    send_frame(8'h00, 8'hee, 2'd2, c3, 0, -1, 1);
    chk("ovw.constants", 128'(constants), c2);

    // Commit and switch to the same entry in the same cycle.
    do_reset();
    send_frame(8'h00, 8'h11, 2'd1, c1, 0, -1, 1);
    send_frame(8'h00, 8'h21, 2'd3, c2, 0, -1, 1);
    send_frame(8'h00, 8'h22, 2'd3, c4, 0, -1, 0);
    sw_req  = 1'b1;
    sw_idx  = 2'd3;
    fu_idle = 1'b1;
    tick();
    chk("sim.stall_ack", 128'(sw_ack), '0);
    model_frame(8'h00, 8'h22, 2'd3, c4, 0);
    tick();
    chk("sim.ack", 128'(sw_ack), 128'(1));
    m_act = 2'd3;
    chk_state("sim");
    chk("sim.cfg_op", 128'(cfg_op), 128'(8'h22));
    sw_req = 1'b0;
    tick();
    chk("sim.pulse", 128'(sw_ack), '0);

    // Reset in the middle of a frame; only the fresh frame may commit.
    cfg_in_vld = 1'b1;
    cfg_in_data = {8'h00, 14'd0, 2'd0, 8'h44};
`ifdef UCORE_CFG_PARITY_EN
    cfg_in_par = ^cfg_in_data;
`endif
    tick();
    cfg_in_data = 32'hdead0001;
`ifdef UCORE_CFG_PARITY_EN
    cfg_in_par = ^cfg_in_data;
`endif
    tick();
    cfg_in_data = 32'hdead0002;
`ifdef UCORE_CFG_PARITY_EN
    cfg_in_par = ^cfg_in_data;
`endif
    tick();
    do_reset();
    tick();
    tick();
    chk_state("after_mid_reset");
    send_frame(8'h00, 8'h66, 2'd2, c5, 0, -1, 1);
    chk("fresh.constants", 128'(constants), c5);
    chk("fresh.entry_vld", 128'(entry_vld), 128'(4'b0100));

`ifdef UCORE_CFG_PARITY_EN
    // Corrupted beat blocks the commit; the next clean frame commits.
    do_reset();
    send_frame(8'h00, 8'h31, 2'd1, c1, 0, 3, 1);
    chk("par.entry_vld", 128'(entry_vld), '0);
    chk("par.cfg_err", 128'(cfg_err), 128'(1));
    send_frame(8'h00, 8'h32, 2'd1, c2, 0, -1, 1);
    chk("par.clean_op", 128'(cfg_op), 128'(8'h32));
`endif

    // Randomized frames and switches against the reference model.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      int r;
      r = int'($urandom_range(9, 0));
      if (r < 6) begin
        logic [7:0] id;
        id = (r == 0) ? 8'h01 : ((r == 1) ? 8'ha5 : UCORE_ID);
        send_frame(id, 8'($urandom), 2'($urandom_range(3, 0)),
                   {$urandom(), $urandom(), $urandom(), $urandom()}, 2, -1, 1);
      end else begin
        do_switch(2'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
